frq_divider_multi: RTL and testbench
====================================

Name: frq_divider_multi

Overview:
Parametrised multi-channel successor to the single ROM-controlled frequency divider. Each channel has a 5-bit frequency select that indexes an internal divisor ROM and produces a divided clock-enable-style output. New behaviour per channel:
- glitch-free divisor switching at period boundaries
- run/stop enable with no runt pulses
- 50%-duty or single-pulse output mode
- period-boundary tick and pending-status flags

All channels run in the system clock domain; outputs are registered.

Parameters:
CHANNELS, 2, number of independent divider channels
SEL_W, 5, width of each channel's frequency-select field (ROM depth = 2^SEL_W)
CNT_W, 16, width of the per-channel half-period counter
HALF_BASE, 1, ROM scale factor: half(sel) = (sel+1)*HALF_BASE, saturated to 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
en  input  CHANNELS  per-channel run enable
mode  input  CHANNELS  per-channel output mode: 0 = 50% duty, 1 = single-cycle pulse
sel_load  input  CHANNELS  per-channel strobe: capture the channel's f_select slice
f_select  input  CHANNELS*SEL_W  channel i uses bits [i*SEL_W +: SEL_W]
clk_out  output  CHANNELS  divided output per channel
period_tick  output  CHANNELS  one-cycle pulse on the last cycle of each completed period
pending  output  CHANNELS  1 while a loaded select waits to be applied

Behaviour:
- Reset (async, any time, including mid-period):
  - all outputs go 0 immediately
  - state IDLE, active_sel = 0, pending_sel = 0, pending = 0, counter = 0
- ROM: combinational, half(sel) = (sel+1)*HALF_BASE. Full period = 2*half(sel) clk cycles. With defaults, sel 0 -> /2 and sel 31 -> /64.
- Per-channel FSM states: IDLE, HIGH, LOW.
- IDLE:
  - clk_out = 0
  - sel_load applies f_select directly to active_sel next edge; pending stays 0
  - en = 1 -> HIGH next edge, counter = half(active_sel)-1, clk_out = 1 from that edge (1-cycle latency)
- HIGH:
  - mode 0: clk_out = 1; mode 1: clk_out = 1 only on the first HIGH cycle, 0 after
  - counter decrements each cycle; at 0 -> LOW, counter = half(active_sel)-1
- LOW:
  - clk_out = 0; counter decrements
  - at 0, the boundary cycle:
    - period_tick = 1 (registered, asserted during this cycle)
    - if pending, active_sel = pending_sel and pending clears
    - then en = 1 -> HIGH with counter = half(new active_sel)-1; en = 0 -> IDLE
- sel_load while HIGH/LOW: pending_sel = slice, pending = 1. A repeat load overwrites pending_sel. The running period is never shortened or stretched.
- sel_load on a boundary cycle: the new slice takes effect for the period starting at that boundary; pending is not left set.
- en deasserted mid-period: the current period completes (full HIGH and LOW phases), then IDLE. en reasserted before the boundary -> continuous run, no gap.
- mode change mid-period: takes effect on the next cycle's clk_out (combinational on state/counter); no effect on timing.
- Channels are fully independent; no shared state except the ROM function.
- Counter width rule: half saturates at 2^CNT_W-1; counter never wraps below 0.

Test Plan:
- Reset, ch0 sel_load f=0, en = 1, mode = 0 -> clk_out 1,0,1,0…; period_tick on every LOW cycle; first clk_out = 1 one edge after en.
- ch0 sel = 2, mode = 0 -> clk_out 3 high / 3 low; period_tick every 6 cycles on the 3rd low cycle.
- Running sel = 2, sel_load f = 0 on 2nd HIGH cycle -> pending = 1; current 6-cycle period completes; pending clears at boundary; next periods are 2 cycles.
- Running sel = 3, mode = 1 -> clk_out high 1 cycle per 8; period_tick on cycle 8.
- sel = 2, drop en on 1st HIGH cycle -> 3 high + 3 low complete, then clk_out held 0, state IDLE; async reset asserted mid-HIGH in another run -> clk_out 0 without a clock edge.
- CHANNELS = 2: ch0 sel = 0 and ch1 sel = 4 (period 10) run together; ch1 sel_load during ch0 boundary -> ch0 timing unaffected; each tick at its own period.

Source files
------------

// File: rtl/frq_divider_multi.sv
// frq_divider_multi: multi-channel ROM-selected clock divider with boundary-aligned reselect
module frq_divider_multi #(
    parameter int CHANNELS  = 2,
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 16,
    parameter int HALF_BASE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       sel_load,
    input  logic [CHANNELS*SEL_W-1:0] f_select,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       period_tick,
    output logic [CHANNELS-1:0]       pending
);
    localparam int PW = SEL_W + 33;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // half(sel)-1, saturated at the counter's full scale and floored at zero
    function automatic logic [CNT_W-1:0] reload(input logic [SEL_W-1:0] s);
        logic [PW-1:0] p;
        p = ({33'd0, s} + PW'(1)) * PW'(HALF_BASE);
        if (p > PW'({CNT_W{1'b1}})) p = PW'({CNT_W{1'b1}});
        return p == '0 ? '0 : CNT_W'(p - PW'(1));
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           st, st_n;
        logic [CNT_W-1:0] cnt, cnt_n;
        logic [SEL_W-1:0] act, act_n, psel, psel_n, slice;
        logic             pend, pend_n, co, tk, bnd;

        assign slice          = f_select[i*SEL_W +: SEL_W];
        assign bnd            = st == LOW && cnt == '0;
        assign clk_out[i]     = co;
        assign period_tick[i] = tk;
        assign pending[i]     = pend;

        // next state: selects are only swapped on the LOW-phase boundary so periods never change length
        always_comb begin
            st_n   = st;
            cnt_n  = cnt - CNT_W'(1);
            act_n  = act;
            psel_n = psel;
            pend_n = pend;
            if (st != IDLE && sel_load[i] && !bnd) begin
                psel_n = slice;
                pend_n = 1'b1;
            end
            case (st)
                IDLE: begin
                    act_n = sel_load[i] ? slice : act;
                    st_n  = en[i] ? HIGH : IDLE;
                    cnt_n = en[i] ? reload(act_n) : '0;
                end
                HIGH: begin
                    st_n  = cnt == '0 ? LOW : HIGH;
                    cnt_n = cnt == '0 ? reload(act) : cnt - CNT_W'(1);
                end
                LOW: begin
                    if (bnd) begin
                        act_n  = sel_load[i] ? slice : pend ? psel : act;
                        pend_n = 1'b0;
                        st_n   = en[i] ? HIGH : IDLE;
                        cnt_n  = en[i] ? reload(act_n) : '0;
                    end
                end
                default: begin
                    st_n  = IDLE;
                    cnt_n = '0;
                end
            endcase
        end

        // channel state and look-ahead registered outputs
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st   <= IDLE;
                cnt  <= '0;
                act  <= '0;
                psel <= '0;
                pend <= 1'b0;
                co   <= 1'b0;
                tk   <= 1'b0;
            end else begin
                st   <= st_n;
                cnt  <= cnt_n;
                act  <= act_n;
                psel <= psel_n;
                pend <= pend_n;
                co   <= st_n == HIGH && (!mode[i] || st != HIGH);
                tk   <= st_n == LOW && cnt_n == '0;
            end
        end
    end
endmodule

// File: tb/tb_frq_divider_multi.sv
// tb_frq_divider_multi: directed scoreboard bench for the multi-channel divider
module tb_frq_divider_multi;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] en, mode, sel_load, clk_out, period_tick, pending;
    logic [9:0] f_select;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    frq_divider_multi dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_load(sel_load),
        .f_select(f_select), .clk_out(clk_out), .period_tick(period_tick), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic co, input logic tk, input logic pd);
        if (ch == 0) q0.push_back({co, tk, pd});
        else q1.push_back({co, tk, pd});
    endtask

    task automatic push_period(input int ch, input int h, input logic m);
        for (int k = 0; k < h; k++) push(ch, m ? logic'(k == 0) : 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < h; k++) push(ch, 1'b0, logic'(k == h - 1), 1'b0);
    endtask

    task automatic run(input int n, input string tag);
        logic [2:0] e0, e1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            e0 = q0.size() != 0 ? q0.pop_front() : 3'b000;
            e1 = q1.size() != 0 ? q1.pop_front() : 3'b000;
            chk($sformatf("%s[%0d] ch0 clk_out", tag, c), clk_out[0], e0[2]);
            chk($sformatf("%s[%0d] ch0 tick", tag, c), period_tick[0], e0[1]);
            chk($sformatf("%s[%0d] ch0 pending", tag, c), pending[0], e0[0]);
            chk($sformatf("%s[%0d] ch1 clk_out", tag, c), clk_out[1], e1[2]);
            chk($sformatf("%s[%0d] ch1 tick", tag, c), period_tick[1], e1[1]);
            chk($sformatf("%s[%0d] ch1 pending", tag, c), pending[1], e1[0]);
        end
    endtask

    initial begin
        reset = 1'b1; en = '0; mode = '0; sel_load = '0; f_select = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset clk_out", clk_out, 2'b00);
        chk("reset tick", period_tick, 2'b00);
        chk("reset pending", pending, 2'b00);
        reset = 1'b0;
        sel_load = 2'b01; f_select = 10'd0;
        run(1, "load0");
        sel_load = '0; en = 2'b01;
        repeat (3) push_period(0, 1, 1'b0);
        run(6, "div2");
        sel_load = 2'b01; f_select = 10'd2;
        repeat (2) push_period(0, 3, 1'b0);
        run(1, "div6");
        sel_load = '0;
        run(11, "div6");
        push(0, 1, 0, 0); push(0, 1, 0, 0); push(0, 1, 0, 1);
        push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 1, 1);
        repeat (2) push_period(0, 1, 1'b0);
        run(2, "pend");
        sel_load = 2'b01; f_select = 10'd0;
        run(1, "pend");
        sel_load = '0;
        run(7, "pend");
        sel_load = 2'b01; f_select = 10'd3; mode = 2'b01;
        repeat (2) push_period(0, 4, 1'b1);
        run(1, "pulse");
        sel_load = '0;
        run(15, "pulse");
        sel_load = 2'b01; f_select = 10'd2; mode = '0;
        push_period(0, 3, 1'b0);
        run(1, "stop");
        sel_load = '0; en = '0;
        run(8, "stop");
        en = 2'b01;
        push(0, 1, 0, 0);
        run(1, "arst");
        #2 reset = 1'b1;
        #1;
        chk("async clk_out", clk_out, 2'b00);
        chk("async tick", period_tick, 2'b00);
        chk("async pending", pending, 2'b00);
        en = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        sel_load = 2'b11; f_select = {5'd4, 5'd0};
        run(1, "dual");
        sel_load = '0; en = 2'b11;
        repeat (7) push_period(0, 1, 1'b0);
        for (int k = 1; k <= 14; k++)
            push(1, logic'(k <= 5 || k == 11 || k == 13), logic'(k == 10 || k == 12 || k == 14),
                 logic'(k >= 3 && k <= 10));
        run(2, "dual");
        sel_load = 2'b10; f_select = 10'd0;
        run(1, "dual");
        sel_load = '0;
        run(11, "dual");
        chk("ch0 queue drained", logic'(q0.size() == 0), 2'b01);
        chk("ch1 queue drained", logic'(q1.size() == 0), 2'b01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
